// File: rtl/ex_flag_unit_pkg.sv
// Shared definitions for the EX-stage flag unit: condition codes and FSM states.
package ex_flag_unit_pkg;

    // Branch condition codes carried by the instruction in ID
    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // Flag hazard tracking states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/dff.sv
// Single-bit storage cell with write enable and asynchronous active-high reset.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic wen,
    input  logic d,
    output logic q
);

    // Capture d when enabled, clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else if (wen)
            q <= d;
    end

endmodule

// File: rtl/ex_flag_unit_branch_cond_eval.sv
// Combinational condition-code decoder: cond x {N,V,Z} -> taken.
module branch_cond_eval
    import ex_flag_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_z,
    output logic       taken
);

    // Decode the condition against the supplied flags
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_NEQ:    taken = ~flag_z;
            COND_EQ:     taken = flag_z;
            COND_GT:     taken = ~flag_z & ~flag_n;
            COND_LT:     taken = flag_n;
            COND_GTE:    taken = flag_z | ~flag_n;
            COND_LTE:    taken = flag_n | flag_z;
            COND_OVFL:   taken = flag_v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_flag_unit.sv
// EX-stage flag register, branch resolution for ID, and flag RAW hazard stall.
module ex_flag_unit
    import ex_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              ex_flush,
    input  logic              set_N_in,
    input  logic              set_V_in,
    input  logic              set_Z_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    input  logic              id_branch,
    input  logic [2:0]        id_cond,
    output logic              flag_N,
    output logic              flag_V,
    output logic              flag_Z,
    output logic              branch_taken,
    output logic              flag_hazard,
    output logic [CNT_W-1:0]  hazard_cycles
);

    logic   commit;
    logic   any_set;
    logic   cond_taken;
    state_e state;

    assign commit  = ex_valid & ~ex_stall & ~ex_flush;
    assign any_set = set_N_in | set_V_in | set_Z_in;

    dff u_flag_n (.clk(clk), .rst(rst), .wen(set_N_in & commit), .d(alu_result[DATA_W-1]), .q(flag_N));
    dff u_flag_v (.clk(clk), .rst(rst), .wen(set_V_in & commit), .d(alu_ovf),              .q(flag_V));
    dff u_flag_z (.clk(clk), .rst(rst), .wen(set_Z_in & commit), .d(alu_result == '0),     .q(flag_Z));

    // A stalled setter stays in EX, so the hazard naturally persists until it commits
    assign flag_hazard = id_branch & (id_cond != COND_UNCOND) & ex_valid & ~ex_flush & any_set;

    branch_cond_eval u_cond (
        .cond   (id_cond),
        .flag_n (flag_N),
        .flag_v (flag_V),
        .flag_z (flag_Z),
        .taken  (cond_taken)
    );

    assign branch_taken = id_branch & cond_taken;

    // Hazard tracking FSM: WAIT while the ID branch is held behind a flag setter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state <= flag_hazard ? ST_WAIT : ST_IDLE;
                ST_WAIT: state <= flag_hazard ? ST_WAIT : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of hazard stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hazard_cycles <= '0;
        else if (flag_hazard && (hazard_cycles != '1))
            hazard_cycles <= hazard_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_ex_flag_unit.sv
// Self-checking bench for ex_flag_unit: behavioural model plus directed literal checks.
module tb_ex_flag_unit;
    import ex_flag_unit_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_stall, ex_flush;
    logic          set_N_in, set_V_in, set_Z_in;
    logic [DW-1:0] alu_result;
    logic          alu_ovf;
    logic          id_branch;
    logic [2:0]    id_cond;
    logic          flag_N, flag_V, flag_Z, branch_taken, flag_hazard;
    logic [15:0]   hazard_cycles;
    logic          n4, v4, z4, t4, h4;
    logic [3:0]    hazard_cycles4;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_n, m_v, m_z, m_wait;
    int m_cnt;

    always #5 clk = ~clk;

    ex_flag_unit #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .set_N_in(set_N_in), .set_V_in(set_V_in), .set_Z_in(set_Z_in),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .id_branch(id_branch), .id_cond(id_cond),
        .flag_N(flag_N), .flag_V(flag_V), .flag_Z(flag_Z), .branch_taken(branch_taken),
        .flag_hazard(flag_hazard), .hazard_cycles(hazard_cycles)
    );

    ex_flag_unit #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .set_N_in(set_N_in), .set_V_in(set_V_in), .set_Z_in(set_Z_in),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .id_branch(id_branch), .id_cond(id_cond),
        .flag_N(n4), .flag_V(v4), .flag_Z(z4), .branch_taken(t4),
        .flag_hazard(h4), .hazard_cycles(hazard_cycles4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        return id_branch && (id_cond != 3'd7) && ex_valid && !ex_flush &&
               (set_N_in || set_V_in || set_Z_in);
    endfunction

    // Branch outcome from the signed-compare meaning of each condition
    function automatic bit model_taken(input bit n, input bit v, input bit z, input logic [2:0] c);
        bit neg, zero;
        neg  = n;
        zero = z;
        case (c)
            3'd0: return !zero;
            3'd1: return zero;
            3'd2: return !zero && !neg;
            3'd3: return neg;
            3'd4: return zero || !neg;
            3'd5: return neg || zero;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Model update at each edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_v = 0; m_z = 0; m_wait = 0; m_cnt = 0;
        end else begin
            bit hz;
            hz = model_hazard();
            if (ex_valid && !ex_stall && !ex_flush) begin
                if (set_N_in) m_n = alu_result[DW-1];
                if (set_V_in) m_v = alu_ovf;
                if (set_Z_in) m_z = (alu_result == 0);
            end
            if (hz && m_cnt < 65535) m_cnt = m_cnt + 1;
            m_wait = hz;
        end
    end

    // Continuous compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            bit hz;
            hz = model_hazard();
            check("flag_N", flag_N, m_n);
            check("flag_V", flag_V, m_v);
            check("flag_Z", flag_Z, m_z);
            check("flag_hazard", flag_hazard, hz);
            if (!hz)
                check("branch_taken", branch_taken, id_branch ? model_taken(m_n, m_v, m_z, id_cond) : 1'b0);
            check("hazard_cycles", hazard_cycles, m_cnt);
            check("hazard_cycles4", hazard_cycles4, (m_cnt > 15) ? 15 : m_cnt);
            check("state", (dut.state == ST_WAIT), m_wait);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_stall = 0; ex_flush = 0;
        set_N_in = 0; set_V_in = 0; set_Z_in = 0;
        alu_result = '0; alu_ovf = 0; id_branch = 0; id_cond = 3'd0;
    endtask

    task automatic setter(input logic [DW-1:0] res, input logic ovf);
        ex_valid = 1; set_N_in = 1; set_V_in = 1; set_Z_in = 1;
        alu_result = res; alu_ovf = ovf;
    endtask

    task automatic rand_inputs();
        ex_valid   = ($urandom_range(0, 3) != 0);
        ex_stall   = ($urandom_range(0, 4) == 0);
        ex_flush   = ($urandom_range(0, 6) == 0);
        set_N_in   = $urandom_range(0, 1);
        set_V_in   = $urandom_range(0, 1);
        set_Z_in   = $urandom_range(0, 1);
        alu_result = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
        alu_ovf    = $urandom_range(0, 1);
        id_branch  = $urandom_range(0, 1);
        id_cond    = 3'($urandom_range(0, 7));
    endtask

    logic [7:0] sweep_exp;

    initial begin
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Warm up with random traffic so reset has state to clear
        repeat (50) begin rand_inputs(); tick(); end

        // Mid-cycle asynchronous reset
        idle_inputs();
        #2 rst = 1;
        #1;
        check("rst_flags", {flag_N, flag_V, flag_Z}, 3'b000);
        check("rst_cnt", hazard_cycles, 0);
        check("rst_cnt4", hazard_cycles4, 0);
        check("rst_taken", branch_taken, 0);
        check("rst_state", (dut.state == ST_IDLE), 1);
        tick();
        rst = 0;
        tick();

        // Flag write: only Z enabled
        ex_valid = 1; set_Z_in = 1; alu_result = '0; alu_ovf = 1;
        tick();
        check("fw_nvz", {flag_N, flag_V, flag_Z}, 3'b001);
        // Stalled setter does not write
        ex_stall = 1; setter(16'h8000, 1'b1);
        tick();
        check("fw_stall_nvz", {flag_N, flag_V, flag_Z}, 3'b001);
        idle_inputs();

        // Single-cycle hazard; setter clears Z
        setter(16'h0005, 1'b0); id_branch = 1; id_cond = 3'd1;
        #1 check("hz_on", flag_hazard, 1);
        tick();
        idle_inputs(); id_branch = 1; id_cond = 3'd1;
        #1;
        check("hz_off", flag_hazard, 0);
        check("hz_cnt", hazard_cycles, 1);
        check("hz_taken_newz", branch_taken, 0);
        check("hz_state_wait", (dut.state == ST_WAIT), 1);
        tick();
        check("hz_state_idle", (dut.state == ST_IDLE), 1);

        // Setter held by ex_stall for 3 cycles
        setter('0, 1'b0); ex_stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1 check("st_hz", flag_hazard, 1);
            tick();
            check("st_state", (dut.state == ST_WAIT), 1);
        end
        ex_stall = 0;
        #1 check("st_hz_last", flag_hazard, 1);
        tick();
        ex_valid = 0; set_N_in = 0; set_V_in = 0; set_Z_in = 0;
        #1;
        check("st_hz_off", flag_hazard, 0);
        check("st_cnt", hazard_cycles, 5);
        check("st_taken", branch_taken, 1);
        check("st_state", (dut.state == ST_WAIT), 1);
        tick();

        // Condition sweep with N=1 Z=0 V=0
        idle_inputs(); setter(16'h8000, 1'b0);
        tick();
        idle_inputs(); id_branch = 1;
        sweep_exp = 8'b1010_1001;
        for (int c = 0; c < 8; c++) begin
            id_cond = 3'(c);
            #1 check("sweep_taken", branch_taken, sweep_exp[c]);
            check("sweep_model", model_taken(1'b1, 1'b0, 1'b0, 3'(c)), sweep_exp[c]);
        end

        // Flushed setter: no hazard, flags held
        setter('0, 1'b1); ex_flush = 1; id_cond = 3'd1;
        #1 check("fl_hz", flag_hazard, 0);
        tick();
        check("fl_nvz", {flag_N, flag_V, flag_Z}, 3'b100);
        check("fl_cnt", hazard_cycles, 5);
        ex_flush = 0;

        // Unconditional branch never stalls
        id_cond = 3'd7;
        #1;
        check("uc_hz", flag_hazard, 0);
        check("uc_taken", branch_taken, 1);
        tick();

        // Saturation of the 4-bit counter
        setter('0, 1'b0); ex_stall = 1; id_branch = 1; id_cond = 3'd1;
        repeat (20) tick();
        idle_inputs();
        #1;
        check("sat_cnt", hazard_cycles, 25);
        check("sat_cnt4", hazard_cycles4, 15);
        check("sat_model", m_cnt, 25);

        // Random traffic against the model
        repeat (3000) begin rand_inputs(); tick(); end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
